// File: rtl/adder_accum_amisha_pkg.sv
// Shared definitions for the accumulation stage.
//   state_t       : FSM state encoding (IDLE / ACCUM / DONE)
//   N_DEFAULT     : default operand and accumulator width
//   CNT_W_DEFAULT : default carry-counter width
package adder_accum_amisha_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_DEFAULT     = 8;
  localparam int CNT_W_DEFAULT = 4;

endpackage

// File: rtl/adder_accum_amisha_adder.sv
// Parameterised ripple-carry adder (adder_carry_para_Amisha).
//   a, b : N-bit operands
//   sum  : a + b modulo 2^N
//   cout : carry out of the top bit
module adder_carry_para_Amisha #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = 1'b0;

  // One full adder per bit; carry ripples from bit 0 upwards.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/adder_accum_amisha.sv
// Packet accumulator: sums the N-bit beats of a valid/ready packet, counts
// adder carry-outs (saturating), and holds the result on a valid/ready output
// until it is consumed.
//   clk_amisha, reset_amisha      : clock, synchronous active-high reset
//   in_valid/ready/data/last      : operand stream
//   out_valid/ready               : result handshake
//   out_sum / out_carries / out_ovf : result fields
//   busy_amisha                   : packet in progress (ACCUM)
module adder_accum_amisha
  import adder_accum_amisha_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             in_valid_amisha,
  output logic             in_ready_amisha,
  input  logic [N-1:0]     in_data_amisha,
  input  logic             in_last_amisha,
  output logic             out_valid_amisha,
  input  logic             out_ready_amisha,
  output logic [N-1:0]     out_sum_amisha,
  output logic [CNT_W-1:0] out_carries_amisha,
  output logic             out_ovf_amisha,
  output logic             busy_amisha
);

  state_t            state, state_nxt;
  logic [N-1:0]      acc;
  logic [N-1:0]      add_sum;
  logic              add_cout;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              in_fire, out_fire;

  // Handshake flags are decoded from state only, so in_ready never
  // combinationally depends on in_valid.
  assign in_ready_amisha  = (state != DONE);
  assign out_valid_amisha = (state == DONE);
  assign busy_amisha      = (state == ACCUM);

  assign in_fire  = in_valid_amisha && in_ready_amisha;
  assign out_fire = out_valid_amisha && out_ready_amisha;

  assign out_sum_amisha     = acc;
  assign out_carries_amisha = cnt;
  assign out_ovf_amisha     = ovf;

  adder_carry_para_Amisha #(.N(N)) u_add (
    .a    (acc),
    .b    (in_data_amisha),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (in_fire) state_nxt = in_last_amisha ? DONE : ACCUM;
      DONE:        if (out_fire) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) state <= IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_fire) begin
          // First beat loads directly; no add, so no carry is possible.
          acc <= in_data_amisha;
          cnt <= '0;
          ovf <= 1'b0;
        end
        ACCUM: if (in_fire) begin
          acc <= add_sum;
          if (add_cout) begin
            // Counter sticks at all-ones; further carries only flag ovf.
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
            else           ovf <= 1'b1;
          end
        end
        DONE: if (out_fire) begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accum_amisha.sv
module tb_adder_accum_amisha;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic       in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [7:0] out_sum_a;
  logic [3:0] out_carries_a;
  logic       in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [7:0] out_sum_b;
  logic [1:0] out_carries_b;

  int passed = 0;
  int total  = 0;

  logic [7:0] pkt [0:15];

  always #5 clk = ~clk;

  // Default counter width (4) and a narrow counter (2) see identical stimulus.
  adder_accum_amisha #(.N(8), .CNT_W(4)) dut_a (
    .clk_amisha(clk), .reset_amisha(reset),
    .in_valid_amisha(in_valid), .in_ready_amisha(in_ready_a),
    .in_data_amisha(in_data), .in_last_amisha(in_last),
    .out_valid_amisha(out_valid_a), .out_ready_amisha(out_ready),
    .out_sum_amisha(out_sum_a), .out_carries_amisha(out_carries_a),
    .out_ovf_amisha(out_ovf_a), .busy_amisha(busy_a)
  );

  adder_accum_amisha #(.N(8), .CNT_W(2)) dut_b (
    .clk_amisha(clk), .reset_amisha(reset),
    .in_valid_amisha(in_valid), .in_ready_amisha(in_ready_b),
    .in_data_amisha(in_data), .in_last_amisha(in_last),
    .out_valid_amisha(out_valid_b), .out_ready_amisha(out_ready),
    .out_sum_amisha(out_sum_b), .out_carries_amisha(out_carries_b),
    .out_ovf_amisha(out_ovf_b), .busy_amisha(busy_b)
  );

  // Reference: plain integer sum of the packet; a carry is any step where the
  // running total crosses 256 (first beat is loaded, never added).
  function automatic logic [25:0] model(input int len);
    int s;
    int c;
    s = pkt[0];
    c = 0;
    for (int i = 1; i < len; i++) begin
      s = s + pkt[i];
      if (s > 255) begin
        c++;
        s = s - 256;
      end
    end
    return {1'b1, 1'b1, 8'(s), 8'(s),
            (c > 15) ? 4'd15 : 4'(c), (c > 3) ? 2'd3 : 2'(c),
            (c > 15), (c > 3)};
  endfunction

  function automatic logic [25:0] obs();
    return {out_valid_a, out_valid_b, out_sum_a, out_sum_b,
            out_carries_a, out_carries_b, out_ovf_a, out_ovf_b};
  endfunction

  function automatic logic [3:0] ctrl();
    return {in_ready_a, in_ready_b, busy_a, busy_b};
  endfunction

  // Drives pkt[0..len-1] starting at a negedge; returns at the negedge after
  // the final beat transfers. ok=0 if in_ready never came.
  task automatic send_beats(input int len, input bit last_final, input int gap_max,
                            output bit ok);
    int gap;
    int w;
    ok = 1'b1;
    for (int i = 0; i < len; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = last_final && (i == len - 1);
      w = 0;
      while (!in_ready_a && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready_a) begin
        ok = 1'b0;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== 26'd0) $display("FAIL reset_out: got %h want %h", obs(), 26'd0);
    else passed++;
    total++;
    if (ctrl() !== 4'b1100) $display("FAIL reset_ctrl: got %b want %b", ctrl(), 4'b1100);
    else passed++;
  endtask

  task automatic test_basic();
    bit ok;
    pkt[0] = 8'h10; pkt[1] = 8'h20; pkt[2] = 8'h30;
    out_ready = 1'b1;
    send_beats(3, 1'b1, 0, ok);
    total++;
    if (!ok) $display("FAIL basic_timeout: got ready=%b want 1", in_ready_a);
    else passed++;
    total++;
    if (obs() !== model(3)) $display("FAIL basic_result: got %h want %h", obs(), model(3));
    else passed++;
    total++;
    if (ctrl() !== 4'b0000) $display("FAIL basic_done_ctrl: got %b want %b", ctrl(), 4'b0000);
    else passed++;
    @(negedge clk);
    total++;
    if (obs() !== 26'd0) $display("FAIL basic_one_cycle: got %h want %h", obs(), 26'd0);
    else passed++;
    total++;
    if (ctrl() !== 4'b1100) $display("FAIL basic_idle_ctrl: got %b want %b", ctrl(), 4'b1100);
    else passed++;
  endtask

  task automatic test_carry();
    bit ok;
    pkt[0] = 8'hFF; pkt[1] = 8'h01; pkt[2] = 8'hFF;
    send_beats(3, 1'b1, 0, ok);
    total++;
    if (obs() !== model(3) || !ok)
      $display("FAIL carry_result: got %h want %h", obs(), model(3));
    else passed++;
    @(negedge clk);
    total++;
    if (obs() !== 26'd0) $display("FAIL carry_clear: got %h want %h", obs(), 26'd0);
    else passed++;
  endtask

  task automatic test_single();
    bit ok;
    pkt[0] = 8'hA5;
    send_beats(1, 1'b1, 0, ok);
    total++;
    if (obs() !== model(1) || !ok)
      $display("FAIL single_result: got %h want %h", obs(), model(1));
    else passed++;
    total++;
    if (ctrl() !== 4'b0000) $display("FAIL single_busy: got %b want %b", ctrl(), 4'b0000);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [25:0] exp;
    pkt[0] = 8'h11; pkt[1] = 8'h22;
    out_ready = 1'b0;
    send_beats(2, 1'b1, 0, ok);
    exp = model(2);
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (obs() !== exp || ctrl() !== 4'b0000 || !ok)
        $display("FAIL bp_hold%0d: got %h/%b want %h/%b", k, obs(), ctrl(), exp, 4'b0000);
      else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== 26'd0 || ctrl() !== 4'b1100)
      $display("FAIL bp_release: got %h/%b want %h/%b", obs(), ctrl(), 26'd0, 4'b1100);
    else passed++;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    pkt[0] = 8'h77;
    total++;
    if (obs() !== model(1)) $display("FAIL bp_reload: got %h want %h", obs(), model(1));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    bit ok;
    for (int i = 0; i < 5; i++) pkt[i] = 8'hFF;
    send_beats(5, 1'b1, 0, ok);
    total++;
    if (obs() !== model(5) || !ok)
      $display("FAIL saturate_result: got %h want %h", obs(), model(5));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
    send_beats(2, 1'b0, 0, ok);
    total++;
    if (ctrl() !== 4'b1111 || !ok) $display("FAIL mid_busy: got %b want %b", ctrl(), 4'b1111);
    else passed++;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    total++;
    if (obs() !== 26'd0 || ctrl() !== 4'b1100)
      $display("FAIL mid_reset: got %h/%b want %h/%b", obs(), ctrl(), 26'd0, 4'b1100);
    else passed++;
    pkt[0] = 8'h05;
    send_beats(1, 1'b1, 0, ok);
    total++;
    if (obs() !== model(1) || !ok) $display("FAIL mid_after: got %h want %h", obs(), model(1));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok;
    int len;
    int hold;
    logic [25:0] exp;
    for (int p = 0; p < 10; p++) begin
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++)
        pkt[i] = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 192)) : 8'($urandom);
      out_ready = 1'($urandom_range(1, 0));
      send_beats(len, 1'b1, 2, ok);
      exp = model(len);
      total++;
      if (obs() !== exp || !ok) $display("FAIL rand%0d_result: got %h want %h", p, obs(), exp);
      else passed++;
      if (!out_ready) begin
        hold = $urandom_range(3, 1);
        repeat (hold) @(negedge clk);
        total++;
        if (obs() !== exp) $display("FAIL rand%0d_hold: got %h want %h", p, obs(), exp);
        else passed++;
        out_ready = 1'b1;
      end
      @(negedge clk);
      total++;
      if (obs() !== 26'd0) $display("FAIL rand%0d_clear: got %h want %h", p, obs(), 26'd0);
      else passed++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_single();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
